// File: rtl/riscv_retire_monitor.sv
// riscv_retire_monitor
// Writeback-end observer for the pipelined RISC-V core. It counts retired
// instructions and reports the architectural result of the last one. It
// also detects the halt pair (addi x1,x0,12 ; jalr x0,0(x1)) and keeps the
// cycle and bubble counters used for CPI reporting.
//
// Retirement interface: this block cannot stall the MW stage, so there is
// no ready. A record is taken on any rising edge where RET_VALID=1 and the
// monitor is not halted. When RET_VALID=0 every other RET_* input is a
// don't-care and is never looked at.
module riscv_retire_monitor #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] HALT_IR0 = 32'h00c00093,
    parameter logic [31:0] HALT_IR1 = 32'h00008067
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RET_VALID,
    input  logic [31:0]      RET_IR,
    input  logic             RET_RF_WE,
    input  logic [31:0]      RET_WD,
    input  logic             RET_BR_TAKEN,
    input  logic [11:0]      RET_ST_ADDR,
    output logic [CNT_W-1:0] NUM_INST,
    output logic [31:0]      OUTPUT_PORT,
    output logic             HALT,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        running;
    logic [31:0] out_next;
    logic [6:0]  opcode;
    logic [4:0]  rd;

    assign running = (state != HALTED);
    assign accept  = RET_VALID && running;
    assign opcode  = RET_IR[6:0];
    assign rd      = RET_IR[11:7];

    // Halt-pair detector next state; only accepted retirements move it
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                RUN: begin
                    if (RET_IR == HALT_IR0) state_next = ARMED;
                end
                ARMED: begin
                    if (RET_IR == HALT_IR1)      state_next = HALTED;
                    else if (RET_IR == HALT_IR0) state_next = ARMED;
                    else                         state_next = RUN;
                end
                default: state_next = state;
            endcase
        end
    end

    // Result selection: register write beats branch outcome beats store address
    always_comb begin
        out_next = OUTPUT_PORT;
        if (accept) begin
            if (RET_RF_WE && (rd != 5'd0)) begin
                out_next = RET_WD;
            end else if (opcode == OP_BRANCH) begin
                out_next = {31'b0, RET_BR_TAKEN};
            end else if (opcode == OP_STORE) begin
                out_next = {20'b0, RET_ST_ADDR};
            end
        end
    end

    // FSM state and the registered HALT flag that mirrors it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            HALT  <= 1'b0;
        end else begin
            state <= state_next;
            HALT  <= (state_next == HALTED);
        end
    end

    // Retirement count and architectural result, frozen once halted
    always_ff @(posedge CLK) begin
        if (RST) begin
            NUM_INST    <= '0;
            OUTPUT_PORT <= 32'd0;
        end else if (accept) begin
            NUM_INST    <= NUM_INST + CNT_W'(1);
            OUTPUT_PORT <= out_next;
        end
    end

    // CPI counters: every running cycle, and the running cycles that were bubbles
    always_ff @(posedge CLK) begin
        if (RST) begin
            CYCLE_CNT  <= '0;
            BUBBLE_CNT <= '0;
        end else if (running) begin
            CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
            if (!RET_VALID) begin
                BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Testbench for riscv_retire_monitor: directed retirement records with
// hand-computed expected outputs. A 32-bit instance covers the functional
// behaviour, and a CNT_W=4 instance sharing the same inputs covers wrap.
module tb_riscv_retire_monitor;

  localparam logic [31:0] I_HALT0 = 32'h00c00093; // addi x1,x0,12
  localparam logic [31:0] I_HALT1 = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] I_ADDI5 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_BEQ   = 32'h00000463; // beq x0,x0,8 (rd field = 8)
  localparam logic [31:0] I_SW    = 32'h00102e23; // sw x1,28(x0)
  localparam logic [31:0] I_X0    = 32'h09900013; // addi x0,x0,0x99
  localparam logic [31:0] I_ADD   = 32'h002081b3; // add x3,x1,x2

  // check mask bits
  localparam logic [7:0] M_NUM  = 8'h01;
  localparam logic [7:0] M_OUT  = 8'h02;
  localparam logic [7:0] M_HALT = 8'h04;
  localparam logic [7:0] M_CYC  = 8'h08;
  localparam logic [7:0] M_BUB  = 8'h10;
  localparam logic [7:0] M_N4   = 8'h20;
  localparam logic [7:0] M_C4   = 8'h40;
  localparam logic [7:0] M_B4   = 8'h80;
  localparam logic [7:0] M_ALL  = 8'h1f;

  typedef struct packed {
    logic [31:0] step;
    logic [7:0]  mask;
    logic [31:0] num;
    logic [31:0] out;
    logic        halt;
    logic [31:0] cyc;
    logic [31:0] bub;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ret_valid;
  logic [31:0] ret_ir;
  logic        ret_rf_we;
  logic [31:0] ret_wd;
  logic        ret_br_taken;
  logic [11:0] ret_st_addr;

  logic [31:0] num_inst;
  logic [31:0] output_port;
  logic        halt;
  logic [31:0] cycle_cnt;
  logic [31:0] bubble_cnt;

  logic [3:0]  num_inst4;
  logic [31:0] output_port4;
  logic        halt4;
  logic [3:0]  cycle_cnt4;
  logic [3:0]  bubble_cnt4;

  exp_t exp_q[$];
  int   checks;
  int   passed;
  int   step_no;

  riscv_retire_monitor dut (
    .CLK(clk), .RST(rst), .RET_VALID(ret_valid), .RET_IR(ret_ir),
    .RET_RF_WE(ret_rf_we), .RET_WD(ret_wd), .RET_BR_TAKEN(ret_br_taken),
    .RET_ST_ADDR(ret_st_addr), .NUM_INST(num_inst), .OUTPUT_PORT(output_port),
    .HALT(halt), .CYCLE_CNT(cycle_cnt), .BUBBLE_CNT(bubble_cnt)
  );

  riscv_retire_monitor #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .RET_VALID(ret_valid), .RET_IR(ret_ir),
    .RET_RF_WE(ret_rf_we), .RET_WD(ret_wd), .RET_BR_TAKEN(ret_br_taken),
    .RET_ST_ADDR(ret_st_addr), .NUM_INST(num_inst4), .OUTPUT_PORT(output_port4),
    .HALT(halt4), .CYCLE_CNT(cycle_cnt4), .BUBBLE_CNT(bubble_cnt4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input int step, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL step %0d %s: got %0h required %0h", step, name, got, want);
  endtask

  // monitor / scoreboard: one expectation per cycle, compared after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.mask & M_NUM)  check(e.step, "NUM_INST", num_inst, e.num);
      if (e.mask & M_OUT)  check(e.step, "OUTPUT_PORT", output_port, e.out);
      if (e.mask & M_HALT) check(e.step, "HALT", {31'b0, halt}, {31'b0, e.halt});
      if (e.mask & M_CYC)  check(e.step, "CYCLE_CNT", cycle_cnt, e.cyc);
      if (e.mask & M_BUB)  check(e.step, "BUBBLE_CNT", bubble_cnt, e.bub);
      if (e.mask & M_N4)   check(e.step, "NUM_INST4", {28'b0, num_inst4}, {28'b0, e.num[3:0]});
      if (e.mask & M_C4)   check(e.step, "CYCLE_CNT4", {28'b0, cycle_cnt4}, {28'b0, e.cyc[3:0]});
      if (e.mask & M_B4)   check(e.step, "BUBBLE_CNT4", {28'b0, bubble_cnt4}, {28'b0, e.bub[3:0]});
    end
  end

  // driver: present one record for one cycle and queue the expected outputs
  task automatic drive(input logic r, input logic v, input logic [31:0] ir,
                       input logic we, input logic [31:0] wd, input logic br,
                       input logic [11:0] st, input logic [7:0] mask,
                       input logic [31:0] e_num, input logic [31:0] e_out,
                       input logic e_halt, input logic [31:0] e_cyc,
                       input logic [31:0] e_bub);
    exp_t e;
    @(negedge clk);
    rst          = r;
    ret_valid    = v;
    ret_ir       = ir;
    ret_rf_we    = we;
    ret_wd       = wd;
    ret_br_taken = br;
    ret_st_addr  = st;
    step_no++;
    e.step = step_no; e.mask = mask; e.num = e_num; e.out = e_out;
    e.halt = e_halt; e.cyc = e_cyc; e.bub = e_bub;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle(input logic [7:0] mask);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 12'h0, mask, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic bubble(input logic [7:0] mask, input logic [31:0] n, input logic [31:0] o,
                        input logic h, input logic [31:0] c, input logic [31:0] b);
    drive(1'b0, 1'b0, 'x, 'x, 'x, 'x, 'x, mask, n, o, h, c, b);
  endtask

  initial begin
    checks = 0; passed = 0; step_no = 0;
    rst = 1'b1; ret_valid = 1'b0; ret_ir = 32'h0; ret_rf_we = 1'b0;
    ret_wd = 32'h0; ret_br_taken = 1'b0; ret_st_addr = 12'h0;

    // reset for two cycles; a valid record during reset is discarded
    reset_cycle(M_ALL);
    drive(1'b1, 1'b1, I_ADDI5, 1'b1, 32'd5, 1'b0, 12'h0, M_ALL, 0, 0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, I_ADDI5, 1'b1, 32'd5, 1'b0, 12'h0, M_ALL, 1, 5, 1'b0, 1, 0);
    // bubble carrying X data must not disturb anything
    bubble(M_ALL, 1, 5, 1'b0, 2, 1);

    // output priority
    reset_cycle(M_ALL);
    drive(1'b0, 1'b1, I_BEQ, 1'b0, 32'h0, 1'b1, 12'h0, M_ALL, 1, 32'h1, 1'b0, 1, 0);
    drive(1'b0, 1'b1, I_SW, 1'b0, 32'h0, 1'b0, 12'h01c, M_ALL, 2, 32'h1c, 1'b0, 2, 0);
    drive(1'b0, 1'b1, I_X0, 1'b1, 32'h99, 1'b0, 12'h0, M_ALL, 3, 32'h1c, 1'b0, 3, 0);
    drive(1'b0, 1'b1, I_ADD, 1'b0, 32'h55, 1'b1, 12'h3ff, M_ALL, 4, 32'h1c, 1'b0, 4, 0);
    drive(1'b0, 1'b1, I_BEQ, 1'b1, 32'h77, 1'b1, 12'h0, M_ALL, 5, 32'h77, 1'b0, 5, 0);
    drive(1'b0, 1'b1, I_BEQ, 1'b0, 32'h0, 1'b0, 12'h0, M_ALL, 6, 32'h0, 1'b0, 6, 0);

    // halt pair separated by bubbles, then frozen
    reset_cycle(M_ALL);
    drive(1'b0, 1'b1, I_HALT0, 1'b1, 32'd12, 1'b0, 12'h0, M_ALL, 1, 12, 1'b0, 1, 0);
    bubble(M_ALL, 1, 12, 1'b0, 2, 1);
    bubble(M_ALL, 1, 12, 1'b0, 3, 2);
    bubble(M_ALL, 1, 12, 1'b0, 4, 3);
    drive(1'b0, 1'b1, I_HALT1, 1'b1, 32'h44, 1'b0, 12'h0, M_ALL, 2, 12, 1'b1, 5, 3);
    drive(1'b0, 1'b1, I_ADDI5, 1'b1, 32'd5, 1'b0, 12'h0, M_ALL, 2, 12, 1'b1, 5, 3);
    bubble(M_ALL, 2, 12, 1'b1, 5, 3);
    drive(1'b0, 1'b1, I_SW, 1'b0, 32'h0, 1'b0, 12'h0aa, M_ALL, 2, 12, 1'b1, 5, 3);

    // broken pair, then repeated first half followed by second half
    reset_cycle(M_ALL);
    drive(1'b0, 1'b1, I_HALT0, 1'b1, 32'd12, 1'b0, 12'h0, M_ALL, 1, 12, 1'b0, 1, 0);
    drive(1'b0, 1'b1, I_ADD, 1'b1, 32'd7, 1'b0, 12'h0, M_ALL, 2, 7, 1'b0, 2, 0);
    drive(1'b0, 1'b1, I_HALT1, 1'b1, 32'h44, 1'b0, 12'h0, M_ALL, 3, 7, 1'b0, 3, 0);
    drive(1'b0, 1'b1, I_HALT0, 1'b1, 32'd12, 1'b0, 12'h0, M_ALL, 4, 12, 1'b0, 4, 0);
    drive(1'b0, 1'b1, I_HALT0, 1'b1, 32'd12, 1'b0, 12'h0, M_ALL, 5, 12, 1'b0, 5, 0);
    drive(1'b0, 1'b1, I_HALT1, 1'b1, 32'h44, 1'b0, 12'h0, M_ALL, 6, 12, 1'b1, 6, 0);

    // reset while halted with a valid record present
    drive(1'b1, 1'b1, I_ADDI5, 1'b1, 32'd5, 1'b0, 12'h0, M_ALL, 0, 0, 1'b0, 0, 0);
    bubble(M_ALL, 0, 0, 1'b0, 1, 1);
    // reset while armed forgets the first half
    drive(1'b0, 1'b1, I_HALT0, 1'b1, 32'd12, 1'b0, 12'h0, M_ALL, 1, 12, 1'b0, 2, 1);
    drive(1'b1, 1'b1, I_HALT1, 1'b1, 32'h44, 1'b0, 12'h0, M_ALL, 0, 0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, I_HALT1, 1'b1, 32'h44, 1'b0, 12'h0, M_ALL, 1, 0, 1'b0, 1, 0);

    // NUM_INST wrap on the 4-bit instance: 17 retirements
    reset_cycle(M_ALL | M_N4 | M_C4 | M_B4);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, I_ADD, 1'b1, i, 1'b0, 12'h0,
            (i == 16 || i == 17) ? (M_NUM | M_OUT | M_N4) : 8'h00,
            i, i, 1'b0, i, 0);
    end

    // counter wrap: 20 cycles, every fourth one a bubble (5 bubbles)
    reset_cycle(M_N4 | M_C4 | M_B4);
    for (int i = 1; i <= 20; i++) begin
      if (i % 4 == 0)
        bubble((i == 20) ? (M_NUM | M_CYC | M_BUB | M_N4 | M_C4 | M_B4) : 8'h00,
               15, 0, 1'b0, 20, 5);
      else
        drive(1'b0, 1'b1, I_ADD, 1'b1, 32'h1, 1'b0, 12'h0, 8'h00, 0, 0, 1'b0, 0, 0);
    end

    // drain the scoreboard
    bubble(8'h00, 0, 0, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    check(step_no, "scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
